// File: rtl/gate_scheduler.sv
// Single-gate parking scheduler: queues entry requests, latches one
// pending exit, allocates the four slots and times the gate-open window.
module gate_scheduler #(
    parameter int DOOR_TICKS  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [1:0] exit_slot,
    output logic [3:0] spots,
    output logic [2:0] capacity,
    output logic [2:0] location,
    output logic       door_open,
    output logic       is_full,
    output logic [2:0] wait_count,
    output logic       grant,
    output logic [1:0] grant_slot,
    output logic       reject
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN_EXIT,
        OPEN_ENTRY
    } state_t;

    state_t     state;
    logic       exit_pend;
    logic [1:0] exit_sel;
    logic [3:0] tick_cnt;

    logic [1:0] free_idx;
    logic [2:0] free_cnt;
    logic       entry_ok;
    logic       entry_rej;
    logic       exit_ok;
    logic       exit_rej;
    logic       do_exit;
    logic       do_entry;
    logic       door_done;
    logic [2:0] wait_next;

    // Lowest free slot and free-slot count from the occupancy bitmap
    always_comb begin
        free_idx = 2'd0;
        free_cnt = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!spots[i]) begin
                free_idx = 2'(i);
                free_cnt = free_cnt + 3'd1;
            end
        end
    end

    assign is_full  = (spots == 4'b1111);
    assign capacity = free_cnt;
    assign location = is_full ? 3'd0 : {1'b0, free_idx} + 3'd1;

    // Request capture and dispatch decisions, all from registered state
    always_comb begin
        entry_ok  = entry_req && (wait_count < 3'(QUEUE_DEPTH));
        entry_rej = entry_req && !entry_ok;
        exit_ok   = exit_req && spots[exit_slot] && !exit_pend;
        exit_rej  = exit_req && !exit_ok;
        do_exit   = (state == IDLE) && exit_pend;
        do_entry  = (state == IDLE) && !exit_pend
                    && (wait_count != 3'd0) && !is_full;
        door_done = tick && (tick_cnt + 4'd1 == 4'(DOOR_TICKS));
        wait_next = wait_count
                    + {2'b00, entry_ok}
                    - {2'b00, do_entry};
    end

    // Gate FSM with slot allocation, queue count and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            spots      <= 4'b0000;
            wait_count <= 3'd0;
            exit_pend  <= 1'b0;
            exit_sel   <= 2'd0;
            tick_cnt   <= 4'd0;
            door_open  <= 1'b0;
            grant      <= 1'b0;
            grant_slot <= 2'd0;
            reject     <= 1'b0;
        end else begin
            grant      <= 1'b0;
            reject     <= entry_rej | exit_rej;
            wait_count <= wait_next;
            if (exit_ok) begin
                exit_pend <= 1'b1;
                exit_sel  <= exit_slot;
            end
            case (state)
                IDLE: begin
                    if (do_exit) begin
                        spots[exit_sel] <= 1'b0;
                        exit_pend       <= 1'b0;
                        door_open       <= 1'b1;
                        tick_cnt        <= 4'd0;
                        state           <= OPEN_EXIT;
                    end else if (do_entry) begin
                        spots[free_idx] <= 1'b1;
                        grant           <= 1'b1;
                        grant_slot      <= free_idx;
                        door_open       <= 1'b1;
                        tick_cnt        <= 4'd0;
                        state           <= OPEN_ENTRY;
                    end
                end
                OPEN_EXIT, OPEN_ENTRY: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                    if (door_done) begin
                        door_open <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    door_open <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed bench for gate_scheduler: a per-cycle vector table followed
// by hand-written sequences for fill, overflow, double exit and reset.
module tb_gate_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic [3:0] spots;
    logic [2:0] capacity;
    logic [2:0] location;
    logic       door_open;
    logic       is_full;
    logic [2:0] wait_count;
    logic       grant;
    logic [1:0] grant_slot;
    logic       reject;

    int n_vec = 0;
    int n_bad = 0;

    gate_scheduler #(.DOOR_TICKS(4), .QUEUE_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .entry_req(entry_req),
        .exit_req(exit_req),
        .exit_slot(exit_slot),
        .spots(spots),
        .capacity(capacity),
        .location(location),
        .door_open(door_open),
        .is_full(is_full),
        .wait_count(wait_count),
        .grant(grant),
        .grant_slot(grant_slot),
        .reject(reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic       x;
        logic [1:0] s;
        logic       t;
        logic [3:0] sp;
        int         wc;
        logic       dr;
        logic       gr;
        int         gs;
        logic       rj;
        int         cap;
        int         loc;
        logic       full;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(
        input logic r, input logic e, input logic x,
        input logic [1:0] s, input logic t,
        input logic [3:0] sp, input int wc, input logic dr,
        input logic gr, input int gs, input logic rj,
        input int cap, input int loc, input logic full);
        vec_t v;
        v.r = r; v.e = e; v.x = x; v.s = s; v.t = t;
        v.sp = sp; v.wc = wc; v.dr = dr; v.gr = gr; v.gs = gs;
        v.rj = rj; v.cap = cap; v.loc = loc; v.full = full;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic x,
                         input logic [1:0] s, input logic t);
        reset = r;
        entry_req = e;
        exit_req = x;
        exit_slot = s;
        tick = t;
        @(posedge clk);
        #1;
        reset = 1'b0;
        entry_req = 1'b0;
        exit_req = 1'b0;
        exit_slot = 2'd0;
        tick = 1'b0;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,0, 4'b0000,0,0,0,0,0, 4,1,0);
        tbl[1]  = mk(0,1,0,0,0, 4'b0000,1,0,0,0,0, 4,1,0);
        tbl[2]  = mk(0,0,0,0,0, 4'b0001,0,1,1,0,0, 3,2,0);
        tbl[3]  = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[4]  = mk(0,0,0,0,0, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[5]  = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[6]  = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[7]  = mk(0,0,0,0,1, 4'b0001,0,0,0,0,0, 3,2,0);
        tbl[8]  = mk(0,0,0,0,0, 4'b0001,0,0,0,0,0, 3,2,0);
        tbl[9]  = mk(0,1,1,0,0, 4'b0001,1,0,0,0,0, 3,2,0);
        tbl[10] = mk(0,0,0,0,0, 4'b0000,1,1,0,0,0, 4,1,0);
        tbl[11] = mk(0,0,0,0,1, 4'b0000,1,1,0,0,0, 4,1,0);
        tbl[12] = mk(0,0,0,0,1, 4'b0000,1,1,0,0,0, 4,1,0);
        tbl[13] = mk(0,0,0,0,1, 4'b0000,1,1,0,0,0, 4,1,0);
        tbl[14] = mk(0,0,0,0,1, 4'b0000,1,0,0,0,0, 4,1,0);
        tbl[15] = mk(0,0,0,0,0, 4'b0001,0,1,1,0,0, 3,2,0);
        tbl[16] = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[17] = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[18] = mk(0,0,0,0,1, 4'b0001,0,1,0,0,0, 3,2,0);
        tbl[19] = mk(0,0,0,0,1, 4'b0001,0,0,0,0,0, 3,2,0);
        tbl[20] = mk(0,0,1,3,0, 4'b0001,0,0,0,0,1, 3,2,0);
        tbl[21] = mk(0,0,0,0,0, 4'b0001,0,0,0,0,0, 3,2,0);

        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].s, tbl[i].t);
            chk($sformatf("v%0d spots", i), int'(spots), int'(tbl[i].sp));
            chk($sformatf("v%0d wait", i), int'(wait_count), tbl[i].wc);
            chk($sformatf("v%0d door", i), int'(door_open), int'(tbl[i].dr));
            chk($sformatf("v%0d grant", i), int'(grant), int'(tbl[i].gr));
            chk($sformatf("v%0d gslot", i), int'(grant_slot), tbl[i].gs);
            chk($sformatf("v%0d reject", i), int'(reject), int'(tbl[i].rj));
            chk($sformatf("v%0d cap", i), int'(capacity), tbl[i].cap);
            chk($sformatf("v%0d loc", i), int'(location), tbl[i].loc);
            chk($sformatf("v%0d full", i), int'(is_full), int'(tbl[i].full));
        end

        apply(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
            idle();
            chk($sformatf("fill%0d grant", k), int'(grant), 1);
            chk($sformatf("fill%0d gslot", k), int'(grant_slot), k);
            chk($sformatf("fill%0d spots", k), int'(spots), (1 << (k + 1)) - 1);
            ticks(4);
            chk($sformatf("fill%0d door", k), int'(door_open), 0);
        end
        chk("full flag", int'(is_full), 1);
        chk("full loc", int'(location), 0);
        chk("full cap", int'(capacity), 0);

        apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle();
        chk("queued wait", int'(wait_count), 1);
        chk("queued grant", int'(grant), 0);

        apply(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        chk("exit2 reject", int'(reject), 0);
        idle();
        chk("exit2 spots", int'(spots), 4'b1011);
        chk("exit2 door", int'(door_open), 1);
        chk("exit2 wait", int'(wait_count), 1);
        ticks(4);
        chk("exit2 closed", int'(door_open), 0);
        idle();
        chk("reuse grant", int'(grant), 1);
        chk("reuse gslot", int'(grant_slot), 2);
        chk("reuse spots", int'(spots), 4'b1111);
        chk("reuse wait", int'(wait_count), 0);
        ticks(4);

        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
            chk($sformatf("ovf%0d wait", i), int'(wait_count), (i > 4) ? 4 : i);
            chk($sformatf("ovf%0d reject", i), int'(reject), (i == 5) ? 1 : 0);
        end
        idle();
        chk("ovf reject clr", int'(reject), 0);
        chk("ovf wait hold", int'(wait_count), 4);

        apply(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        chk("dbl first rej", int'(reject), 0);
        apply(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        chk("dbl second rej", int'(reject), 1);
        chk("dbl spots", int'(spots), 4'b1110);
        chk("dbl door", int'(door_open), 1);
        ticks(4);
        idle();
        chk("dbl grant", int'(grant), 1);
        chk("dbl gslot", int'(grant_slot), 0);
        chk("dbl wait", int'(wait_count), 3);
        ticks(1);

        apply(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("rst spots", int'(spots), 0);
        chk("rst wait", int'(wait_count), 0);
        chk("rst door", int'(door_open), 0);
        chk("rst cap", int'(capacity), 4);
        chk("rst loc", int'(location), 1);
        chk("rst full", int'(is_full), 0);
        chk("rst gslot", int'(grant_slot), 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("post rst%0d grant", i), int'(grant), 0);
            chk($sformatf("post rst%0d door", i), int'(door_open), 0);
        end
        chk("post rst spots", int'(spots), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_scheduler.md
Name: gate_scheduler

Overview:
- Arbitrates the single parking gate between entry and exit requests; owns slot allocation for the 4 parking spots.
- Queues entry requests that arrive while the lot is full or the gate is busy, and sequences the gate-open interval.
- Sits between the debounced push-button pulses and the door/full LED blinkers and the multiplexed display.
- Drives occupancy, free capacity, next-free location, door and full status.

Parameters:
- DOOR_TICKS, 4, number of tick pulses the gate stays open per served car (1..15).
- QUEUE_DEPTH, 4, maximum pending entry requests held (1..7).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-clk-wide timing pulse (1 Hz enable from the frequency divider)
- entry_req  input  1  one-clk pulse: car requests entry
- exit_req  input  1  one-clk pulse: car in exit_slot requests exit
- exit_slot  input  2  slot index of exiting car, sampled only with exit_req
- spots  output  4  occupancy bitmap, bit i = slot i occupied
- capacity  output  3  free slot count, 0..4
- location  output  3  lowest free slot index + 1; 0 when full
- door_open  output  1  high while gate open
- is_full  output  1  high when spots == 4'b1111
- wait_count  output  3  pending entry requests, 0..QUEUE_DEPTH
- grant  output  1  one-clk pulse when an entry is admitted
- grant_slot  output  2  slot assigned; valid with grant, holds value otherwise
- reject  output  1  one-clk pulse on dropped request (queue overflow, bad exit, exit already pending)

Behaviour:
- Reset (sync, active-high, dominates all inputs): state IDLE; spots=0; capacity=4; location=1; door_open=0; is_full=0; wait_count=0; grant=0; grant_slot=0; reject=0; pending exit cleared; tick counter 0.
- capacity, location and is_full are combinational from the spots register. location = index of lowest 0 bit + 1.
- Request capture happens every cycle, in every state:
  - entry_req: wait_count++ if < QUEUE_DEPTH; else reject pulse on the next cycle and count unchanged.
  - exit_req with slot occupied and no exit pending: latch exit_slot, set exit_pend.
  - exit_req with slot empty, or with exit_pend already set: reject pulse, request dropped.
- FSM states IDLE, OPEN_EXIT, OPEN_ENTRY:
  - IDLE, exit_pend=1 (priority over entry): go to OPEN_EXIT. On the same edge clear the latched spot bit, clear exit_pend, door_open=1, tick counter=0.
  - IDLE, exit_pend=0, wait_count>0, not full: go to OPEN_ENTRY. On the same edge set the lowest free bit, grant=1, grant_slot=that index, wait_count--, door_open=1, tick counter=0.
  - IDLE, wait_count>0 and full: stay IDLE; requests remain queued.
  - OPEN_EXIT / OPEN_ENTRY: counter increments on each tick. When the counter reaches DOOR_TICKS, return to IDLE with door_open=0 on that edge.
  - Earliest next service is the following clk, so there is a 1-cycle door-closed gap between back-to-back services.
- Latency: a request arriving in IDLE with resources available is served on the 2nd clk edge after the pulse (capture edge, then dispatch edge). grant is asserted 1 cycle after the capture edge.
- Simultaneous entry_req and exit_req in the same cycle: both captured; exit is served first.
- Same-cycle capture and decrement: when a new entry_req is captured on the same edge that wait_count-- is applied for dispatch, the net change is 0. The overflow check uses the pre-dispatch count.
- A freed slot is reusable by a queued entry immediately after the exit service completes.
- An exit request for the slot granted in the current cycle counts as occupied only from the next cycle.
- tick and request pulses wider than one clk are treated as repeated pulses; upstream debouncing guarantees single-cycle pulses.
- Reset mid-service aborts the service: the door closes and the queue is flushed.

Test Plan:
- Reset, then 1 entry_req → grant pulse, grant_slot=0, spots=0001, capacity=3, location=2, door_open high for exactly 4 ticks, wait_count back to 0.
- 5 entry_req spaced ≥6 ticks apart → slots 0,1,2,3 granted in order. 5th leaves is_full=1, location=0, wait_count=1, no grant.
  - Then exit_req slot 2 → spots 1011 during OPEN_EXIT. After the door closes the queued car gets grant_slot=2 and spots=1111.
- Entry and exit (slot 0, occupied) pulsed in the same cycle → OPEN_EXIT first (spots bit0 cleared), then OPEN_ENTRY granting slot 0.
- Lot full, 5 entry_req pulses → wait_count saturates at 4; 5th pulse produces reject, count stays 4.
- exit_req for empty slot 3 → reject pulse; spots, state and door unchanged. A second exit_req while one is pending → reject.
- Assert reset during OPEN_ENTRY with wait_count=2 → next cycle all outputs at reset values; no grant afterward without new requests.
